// File: rtl/timer_multi.sv
// timer_multi: NUM_CH independent down-counters (system/RT/cascade tick) with compare
// output and underflow/compare IRQs behind an 8-bit CPU bus slave.
module timer_multi #(
   parameter int          NUM_CH    = 3,
   parameter int          CNT_W     = 16,
   parameter logic [23:0] BASE_ADDR = 24'h2040
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                clk_ce,
   input  logic                rt_tick,
   input  logic                bus_write,
   input  logic                bus_read,
   input  logic [23:0]         bus_address_in,
   input  logic [7:0]          bus_data_in,
   output logic [7:0]          bus_data_out,
   output logic [2*NUM_CH-1:0] irqs,
   output logic                irq,
   output logic [NUM_CH-1:0]   tout
);
   localparam int NB = CNT_W / 8;
   localparam int NI = 2 * NUM_CH;

   logic [11:0]       r_pre;
   logic [NUM_CH-1:0] r_en, r_oneshot, r_tout;
   logic [1:0]        r_src [NUM_CH];
   logic [3:0]        r_scale [NUM_CH];
   logic [CNT_W-1:0]  r_preset [NUM_CH];
   logic [CNT_W-1:0]  r_compare [NUM_CH];
   logic [CNT_W-1:0]  r_count [NUM_CH];
   logic [NI-1:0]     r_irq_en, r_pend;
   logic [23:0]       w_off;
   logic [19:0]       w_blk;
   logic [3:0]        w_reg, w_k;
   logic [11:0]       w_mask;
   logic              w_casc, w_glb_wr;
   logic [NUM_CH-1:0] w_wr, w_tick, w_run, w_reload, w_uf, w_cmp;
   logic [NI-1:0]     w_set, w_clr;
   logic [7:0]        w_rd;

   assign w_off    = bus_address_in - BASE_ADDR;
   assign w_blk    = w_off[23:4];
   assign w_reg    = w_off[3:0];
   assign w_glb_wr = bus_write && w_blk == 20'(NUM_CH);
   assign w_clr    = w_glb_wr && w_reg == 4'd1 ? bus_data_in[NI-1:0] : '0;

   // Cascade ripples through the channels in index order within one cycle.
   always_comb begin
      w_casc = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_wr[c]      = bus_write && w_blk == 20'(c);
         w_reload[c]  = w_wr[c] && w_reg == 4'd0 && bus_data_in[1];
         w_k          = r_scale[c] > 4'd11 ? 4'd11 : r_scale[c];
         w_mask       = (12'd1 << w_k) - 12'd1;
         w_tick[c]    = r_src[c] == 2'd0 ? clk_ce && (r_pre & w_mask) == w_mask :
                        r_src[c] == 2'd1 ? rt_tick :
                        r_src[c] == 2'd2 ? w_casc : 1'b0;
         w_run[c]     = w_tick[c] && r_en[c] && !w_reload[c];
         w_uf[c]      = w_run[c] && r_count[c] == '0;
         w_cmp[c]     = w_run[c] && r_count[c] == r_compare[c];
         w_set[2*c]   = w_uf[c];
         w_set[2*c+1] = w_cmp[c];
         w_casc       = w_uf[c];
      end
   end

   always_comb begin
      w_rd = 8'h00;
      for (int c = 0; c < NUM_CH; c++)
         if (w_blk == 20'(c)) begin
            w_rd = w_reg == 4'd0 ? {2'b00, r_src[c], 1'b0, r_oneshot[c], 1'b0, r_en[c]} :
                   w_reg == 4'd1 ? {4'h0, r_scale[c]} : 8'h00;
            for (int b = 0; b < NB; b++) begin
               if (w_reg == 4'(4 + b)) w_rd = r_preset[c][8*b +: 8];
               if (w_reg == 4'(8 + b)) w_rd = r_compare[c][8*b +: 8];
               if (w_reg == 4'(12 + b)) w_rd = r_count[c][8*b +: 8];
            end
         end
      if (w_blk == 20'(NUM_CH))
         w_rd = w_reg == 4'd0 ? 8'(r_irq_en) : w_reg == 4'd1 ? 8'(r_pend) : 8'h00;
   end

   assign bus_data_out = bus_read ? w_rd : 8'h00;
   assign irqs         = r_pend & r_irq_en;
   assign irq          = |irqs;
   assign tout         = r_tout;

   // RELOAD is never stored: it acts on the write edge and always reads back 0.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         r_pre     <= '0;
         r_en      <= '0;
         r_oneshot <= '0;
         r_tout    <= '0;
         r_irq_en  <= '0;
         r_pend    <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            r_src[c]     <= '0;
            r_scale[c]   <= '0;
            r_preset[c]  <= '0;
            r_compare[c] <= '0;
            r_count[c]   <= '0;
         end
      end else begin
         r_pre  <= r_pre + 12'(clk_ce);
         r_pend <= (r_pend & ~w_clr) | w_set;
         if (w_glb_wr && w_reg == 4'd0) r_irq_en <= bus_data_in[NI-1:0];
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_run[c]) r_count[c] <= w_uf[c] ? r_preset[c] : r_count[c] - CNT_W'(1);
            if (w_uf[c] || w_cmp[c]) r_tout[c] <= !w_cmp[c];
            if (w_uf[c] && r_oneshot[c]) r_en[c] <= 1'b0;
            if (w_reload[c]) r_count[c] <= r_preset[c];
            if (w_wr[c] && w_reg == 4'd0)
               {r_src[c], r_oneshot[c], r_en[c]} <= {bus_data_in[5:4], bus_data_in[2], bus_data_in[0]};
            if (w_wr[c] && w_reg == 4'd1) r_scale[c] <= bus_data_in[3:0];
            for (int b = 0; b < NB; b++) begin
               if (w_wr[c] && w_reg == 4'(4 + b)) r_preset[c][8*b +: 8] <= bus_data_in;
               if (w_wr[c] && w_reg == 4'(8 + b)) r_compare[c][8*b +: 8] <= bus_data_in;
            end
         end
      end
endmodule
